// File: rtl/kpg_add_seq.sv
// rtl/kpg_add_seq.sv - sequential kill/propagate/generate prefix adder
//
// Purpose: adds a + b + cin over several clock cycles. Each bit position is
// reduced to a kill/propagate/generate status, and those statuses are resolved
// with a log-depth prefix merge, one stage per cycle. Carries are then read
// back from the resolved statuses.
// Optional feature: define KPG_ADD_SEQ_OVF_EN to add the registered signed
// overflow output ovf.
//
// Ports:
//   clk   - clock; all state changes on the rising edge
//   rst   - asynchronous active-high reset
//   start - begin an add; only honoured in IDLE
//   a, b  - WIDTH-bit operands, latched on the accept edge
//   cin   - carry-in, latched on the accept edge
//   busy  - high whenever the FSM is not in IDLE
//   done  - one-cycle pulse when sum/cout are updated
//   sum   - registered result (modulo 2^WIDTH), held between operations
//   cout  - registered carry-out, held between operations
//   ovf   - (KPG_ADD_SEQ_OVF_EN only) registered signed overflow
module kpg_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef KPG_ADD_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int KW    = $clog2(LOG2W + 1);

  typedef enum logic [1:0] {IDLE, GEN, MERGE, SUM} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [KW-1:0]    k;

  // Status entry j is {stp[j], stg[j]}: 2'b10 propagate, 2'b01 generate,
  // 2'b00 kill. Entry 0 holds the carry-in, entry i+1 holds operand bit i.
  logic [WIDTH:0]   stp;
  logic [WIDTH:0]   stg;

  // One merge stage: entry j combines with entry j-span. A propagate entry
  // takes the lower status; generate and kill keep their own. Entries below
  // span see p=1/g=0 shifted in, which leaves them unchanged.
  logic [LOG2W:0]   span;
  logic [WIDTH:0]   low_mask;
  logic [WIDTH:0]   lo_p;
  logic [WIDTH:0]   lo_g;
  logic [WIDTH:0]   mrg_p;
  logic [WIDTH:0]   mrg_g;

  always_comb begin
    span     = (LOG2W + 1)'(1) << k;
    low_mask = ~({(WIDTH + 1){1'b1}} << span);
    lo_p     = (stp << span) | low_mask;
    lo_g     = stg << span;
    mrg_p    = stp & lo_p;
    mrg_g    = stg | (stp & lo_g);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      k     <= '0;
      stp   <= '0;
      stg   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef KPG_ADD_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
            state <= GEN;
          end
        end
        GEN: begin
          stp   <= {a_q ^ b_q, 1'b0};
          stg   <= {a_q & b_q, cin_q};
          k     <= '0;
          state <= MERGE;
        end
        MERGE: begin
          stp <= mrg_p;
          stg <= mrg_g;
          // The final stage (span = WIDTH) lets entry WIDTH reach entry 0.
          if (k == KW'(LOG2W)) begin
            state <= SUM;
          end else begin
            k <= k + KW'(1);
          end
        end
        SUM: begin
          // After merging, entry i is generate exactly when a carry enters bit i.
          sum   <= a_q ^ b_q ^ stg[WIDTH-1:0];
          cout  <= stg[WIDTH];
`ifdef KPG_ADD_SEQ_OVF_EN
          ovf   <= stg[WIDTH-1] ^ stg[WIDTH];
`endif
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kpg_add_seq.sv
// tb/tb_kpg_add_seq.sv - self-checking bench for kpg_add_seq
module tb_kpg_add_seq;

  localparam int W   = 32;
  localparam int LAT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef KPG_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard entries are {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];

  kpg_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef KPG_ADD_SEQ_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    logic [W:0] s;
    logic       v;
    s = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    v = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
    return {v, s};
  endfunction

  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        output int acc);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc   = cyc;
    exp_q.push_back(model(ta, tb_v, tc));
  endtask

  task automatic wait_done(output int dc, output bit ok);
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h want=0", sum); end
    checks++;
    if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", cout); end
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W+1:0] e;
    int acc, dc;
    bit ok;
    va[0] = 32'h0000_0001; vb[0] = 32'hFFFF_FFFF; vc[0] = 1'b0;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 1'b0;
    va[2] = 32'h0000_0000; vb[2] = 32'hFFFF_FFFF; vc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], vc[i], acc);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL vec%0d_busy got=%b want=1", i, busy); end
      wait_done(dc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL vec%0d_timeout got=no_done want=done", i); end
      else begin
        e = exp_q.pop_front();
        checks++;
        if (dc - acc !== LAT) begin
          errors++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, dc - acc, LAT);
        end
        checks++;
        if ({cout, sum} !== e[W:0]) begin
          errors++; $display("FAIL vec%0d_result got=%b_%h want=%b_%h", i, cout, sum, e[W], e[W-1:0]);
        end
`ifdef KPG_ADD_SEQ_OVF_EN
        checks++;
        if (ovf !== e[W+1]) begin errors++; $display("FAIL vec%0d_ovf got=%b want=%b", i, ovf, e[W+1]); end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL vec%0d_done_width got=%b want=0", i, done); end
        checks++;
        if ({cout, sum} !== e[W:0]) begin
          errors++; $display("FAIL vec%0d_hold got=%b_%h want=%b_%h", i, cout, sum, e[W], e[W-1:0]);
        end
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [W:0]   prev;
    logic [W+1:0] e;
    int acc, dc, pulses;
    bit ok;
    prev = {cout, sum};
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, acc);
    @(posedge clk);
    #1;
    a     = 32'hFFFF_0000;
    b     = 32'h0F0F_0F0F;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({cout, sum} !== prev) begin
      errors++; $display("FAIL ign_hold_midop got=%b_%h want=%b_%h", cout, sum, prev[W], prev[W-1:0]);
    end
    wait_done(dc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ign_timeout got=no_done want=done"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (dc - acc !== LAT) begin errors++; $display("FAIL ign_latency got=%0d want=%0d", dc - acc, LAT); end
      checks++;
      if ({cout, sum} !== e[W:0]) begin
        errors++; $display("FAIL ign_result got=%b_%h want=%b_%h", cout, sum, e[W], e[W-1:0]);
      end
    end
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL ign_extra_done got=%0d want=0", pulses); end
  endtask

  task automatic test_reset_abort;
    logic [W+1:0] e;
    int acc, dc, pulses;
    bit ok;
    launch(32'h0000_AAAA, 32'h0000_5555, 1'b1, acc);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++; $display("FAIL abort_outputs got=%b%b%b_%h want=000_0", busy, done, cout, sum);
    end
    rst = 1'b0;
    exp_q.delete();
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_done got=%0d want=0", pulses); end
    launch(32'd5, 32'd3, 1'b0, acc);
    wait_done(dc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_restart_timeout got=no_done want=done"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if ({cout, sum} !== e[W:0]) begin
        errors++; $display("FAIL abort_restart got=%b_%h want=%b_%h", cout, sum, e[W], e[W-1:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W+1:0] e;
    int acc, d1, d2;
    bit ok1, ok2;
    @(negedge clk);
    a     = 32'hDEAD_BEEF;
    b     = 32'h2152_4111;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    exp_q.push_back(model(32'hDEAD_BEEF, 32'h2152_4111, 1'b1));
    a   = 32'h8000_0000;
    b   = 32'h8000_0001;
    cin = 1'b0;
    wait_done(d1, ok1);
    exp_q.push_back(model(32'h8000_0000, 32'h8000_0001, 1'b0));
    checks++;
    if (!ok1) begin errors++; $display("FAIL b2b_first_timeout got=no_done want=done"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (d1 - acc !== LAT) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", d1 - acc, LAT); end
      checks++;
      if ({cout, sum} !== e[W:0]) begin
        errors++; $display("FAIL b2b_first got=%b_%h want=%b_%h", cout, sum, e[W], e[W-1:0]);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d2, ok2);
    checks++;
    if (!ok2) begin errors++; $display("FAIL b2b_second_timeout got=no_done want=done"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (d2 - d1 !== LAT + 1) begin errors++; $display("FAIL b2b_spacing got=%0d want=%0d", d2 - d1, LAT + 1); end
      checks++;
      if ({cout, sum} !== e[W:0]) begin
        errors++; $display("FAIL b2b_second got=%b_%h want=%b_%h", cout, sum, e[W], e[W-1:0]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random;
    logic [W+1:0] e;
    int acc, dc;
    bit ok;
    for (int i = 0; i < 1000; i++) begin
      launch($urandom, $urandom, 1'($urandom_range(0, 1)), acc);
      wait_done(dc, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rand%0d_timeout got=no_done want=done", i);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({cout, sum} !== e[W:0]) begin
          errors++; $display("FAIL rand%0d got=%b_%h want=%b_%h", i, cout, sum, e[W], e[W-1:0]);
        end
`ifdef KPG_ADD_SEQ_OVF_EN
        checks++;
        if (ovf !== e[W+1]) begin errors++; $display("FAIL rand%0d_ovf got=%b want=%b", i, ovf, e[W+1]); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kpg_add_seq.md
KPG_ADD_SEQ -- requirements
Module: kpg_add_seq

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, operand width; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL provide port start, input, 1 bit: request to begin an add.
REQ-005 The block SHALL provide port a, input, WIDTH bits: operand A.
REQ-006 The block SHALL provide port b, input, WIDTH bits: operand B.
REQ-007 The block SHALL provide port cin, input, 1 bit: carry-in.
REQ-008 The block SHALL provide port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-009 The block SHALL provide port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 The block SHALL provide port sum, output, WIDTH bits: registered result.
REQ-011 The block SHALL provide port cout, output, 1 bit: registered carry-out.

Function
REQ-012 The block SHALL encode each bit position as a 2-bit status: 2'b10 propagate (a^b), 2'b01 generate (a&b), 2'b00 kill; 2'b11 never occurs.
REQ-013 The block SHALL hold a (WIDTH+1)-entry status vector: entry 0 is the carry-in (generate if cin=1, else kill); entry i+1 is the status of operand bit i.
REQ-014 Merge rule: when combining status hi with the adjacent lower status lo, the result SHALL be lo if hi is propagate, else hi.
REQ-015 The FSM SHALL have the states IDLE, GEN, MERGE and SUM.
REQ-016 IDLE to GEN: start=1 in IDLE latches a, b and cin on that edge; start in any other state SHALL be ignored, with no effect on the latched operands.
REQ-017 GEN to MERGE: the status vector is computed and registered, and the stage counter is cleared to 0.
REQ-018 MERGE: each cycle at stage k, every entry j>=2^k SHALL merge with entry j-2^k (all updates from pre-edge values); entries j<2^k are unchanged.
REQ-019 After log2(WIDTH)+1 merge stages (covering the WIDTH+1 entries), the FSM SHALL go to SUM.
REQ-020 SUM to IDLE: sum[i] = a[i]^b[i]^(entry i is generate); cout = (entry WIDTH is generate); both registered on the edge into IDLE, with done=1 for exactly the following cycle.
REQ-021 Latency: from the start-accept edge to the edge that raises done SHALL be log2(WIDTH)+3 cycles, fixed (8 cycles for WIDTH=32), independent of the data.
REQ-022 sum and cout SHALL hold their values until the next SUM-to-IDLE edge; they SHALL NOT change during a subsequent operation.
REQ-023 start asserted in the same cycle as done SHALL be accepted, giving back-to-back operations with no idle bubble beyond the done cycle.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; the carry beyond the MSB appears only on cout.

Reset
REQ-025 While rst=1: FSM in IDLE; busy=0, done=0, sum=0, cout=0; operand, status and counter registers cleared.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be handled normally.

Configuration
REQ-027 Macro KPG_ADD_SEQ_OVF_EN: when defined, the block SHALL add output port ovf, 1 bit, equal to the signed overflow (carry into the MSB XOR cout), registered and held like sum, with a reset value of 0.
REQ-028 Without KPG_ADD_SEQ_OVF_EN, the port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 WIDTH=32, a=32'h0000_0001, b=32'hFFFF_FFFF, cin=0 -> sum=0, cout=1, done 8 cycles after the accept edge; ovf=0 if enabled.
REQ-030 a=32'h7FFF_FFFF, b=1, cin=0 -> sum=32'h8000_0000, cout=0, ovf=1 if enabled.
REQ-031 a=0, b=32'hFFFF_FFFF, cin=1 (full propagate chain) -> sum=0, cout=1.
REQ-032 start pulsed at accept+2 with different operands -> ignored; the result matches the first operands, with a single done pulse.
REQ-033 rst asserted at accept+4 for 1 cycle -> no done pulse, outputs 0; a following start with a=5, b=3, cin=0 -> sum=8, cout=0.
REQ-034 start held high across the done cycle -> the second operation completes with done pulses exactly 9 cycles apart; random operands are checked against a+b+cin for 1000 iterations.
